underdesigned_multiplier8_xor_enc64: RTL and testbench
======================================================

Name:
underdesigned_multiplier8_xor_enc64

Overview:
- 8x8 unsigned "underdesigned" (approximate) multiplier built from sixteen 2x2 approximate multiplier blocks. The only approximation is 3*3 = 7 in each block; partial products are summed exactly.
- Logic-locked with 64 XOR-type key gates.
- With the correct 64-bit key the output is the approximate product. Any wrong key bit corrupts one specific internal net.
- Used as a locking-evaluation datapath block. The result is registered once.

Parameters:
- KEY_W, 64, key width (fixed).
- K_CORRECT, 64'hA125EF80FFDBD9B5, unlocking key.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- operand1_i  input  8  unsigned multiplicand A.
- operand2_i  input  8  unsigned multiplier B.
- keyinput  input  64  locking key, treated as quasi-static.
- result_o  output  16  registered approximate product.

Behaviour:
- Reset: asynchronous active-low reset (rst_n low) forces result_o = 16'h0000 immediately. Release is synchronous to clk.
- Latency: 1 cycle.
  - At each rising clk edge, result_o <= F(operand1_i, operand2_i, keyinput).
  - Inputs are not registered separately. There is no handshake; a new operand pair is accepted every cycle.
- 2x2 block U(a,b) for 2-bit a, b:
  - Exact a*b for all cases except a=3, b=3, which gives 3'b111 (7).
  - Output width is 3 bits.
- Slicing:
  - A = {A3,A2,A1,A0} and B = {B3,B2,B1,B0}, each slice 2 bits; slice p covers A[2p+1:2p], slice q covers B[2q+1:2q].
  - Block j = 4*p + q computes pp_j = U(Ap, Bq).
- Summation:
  - sum = sum over j of (pp_j' << 2*(p+q)), computed exactly and mod 2^16. No overflow is possible with the correct key.
  - s[15:0] is the summed value.
- Key sites: 64 sites, each net' = net ^ keyinput[i] ^ K_CORRECT[i].
  - Sites i = 3j+k (k = 0..2) act on pp_j bit k, giving pp_j'.
  - Sites i = 48+m act on s bit m; the result is the value registered into result_o bit m.
  - When keyinput[i] == K_CORRECT[i] the site is transparent. On mismatch, exactly that net is inverted.
  - Key gates may be implemented as XOR or XNOR per bit according to K_CORRECT. The function above is normative.
- Key changes take effect at the next clk edge, like operand changes.
- Reset asserted mid-stream clears result_o at once. The first edge after release registers the current inputs.

Decomposition:
- Shared package holds:
  - KEY_W, K_CORRECT.
  - Operand width 8 and result width 16.
  - Site index constants PP_SITE_BASE = 0 and SUM_SITE_BASE = 48.
- One sub-module: udm2x2, a 2x2 approximate block with 3-bit output, instantiated 16 times.
- Key gating, the adder tree and the output register live in the top level.

Test Plan:
- Correct key, rst_n low: result_o = 0000. Release, then operand1_i = 03, operand2_i = 03: one cycle later result_o = 0007. Then 02*03: result_o = 0006.
- Correct key, sweep corners:
  - FF*FF -> C58F (approximate).
  - 10*10 -> 0100.
  - 00*xx -> 0000.
  - FF*01 -> 00FF.
  - Exhaustive 65536 pairs versus a golden model of the approximate multiplier.
- Key 64'hA125EF80FFDBD9A5 (bit 4 flipped: pp_1 bit 1), operands 00*00 -> 0008.
- Key 64'hA325EF80FFDBD9B5 (bit 57 flipped: sum bit 9), operands 00*00 -> 0200. With 03*03 -> 0207.
- Key with bit 48 flipped, operands 00*00 -> 0001. Multi-bit wrong keys (Hamming distance 2/3/4/6) must match the golden model with the corresponding inversions.
- Assert rst_n low mid-sequence, asynchronous to clk: result_o goes to 0000 immediately and holds until rst_n is high and the next clk edge.

Source files
------------

// File: rtl/underdesigned_multiplier8_xor_enc64_pkg.sv
// Shared constants for the key-locked 8x8 approximate multiplier: widths,
// the unlocking key and where each group of key sites begins.
package underdesigned_multiplier8_xor_enc64_pkg;

  localparam int KEY_W         = 64;
  localparam logic [KEY_W-1:0] K_CORRECT = 64'hA125EF80FFDBD9B5;

  localparam int OP_W          = 8;
  localparam int RES_W         = 16;
  localparam int SLICE_W       = 2;
  localparam int SLICES        = OP_W / SLICE_W;
  localparam int NUM_BLK       = SLICES * SLICES;
  localparam int PP_W          = 3;

  localparam int PP_SITE_BASE  = 0;
  localparam int SUM_SITE_BASE = 48;

endpackage : underdesigned_multiplier8_xor_enc64_pkg

// File: rtl/underdesigned_multiplier8_xor_enc64_udm2x2.sv
// 2x2 approximate multiplier block: exact except 3*3, which yields 3'b111 so
// the product always fits in three bits.
module udm2x2
  import underdesigned_multiplier8_xor_enc64_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  output logic [PP_W-1:0]    y_o
);

  // Dropping the carry into bit 3 of 3*3 turns 9 into 7; every other case is exact.
  assign y_o[0] = a_i[0] & b_i[0];
  assign y_o[1] = (a_i[1] & b_i[0]) | (a_i[0] & b_i[1]);
  assign y_o[2] = a_i[1] & b_i[1];

endmodule : udm2x2

// File: rtl/underdesigned_multiplier8_xor_enc64.sv
// Key-locked 8x8 approximate multiplier: sixteen 2x2 blocks, XOR key gates on
// every partial-product bit and every sum bit, one output register.
module underdesigned_multiplier8_xor_enc64
  import underdesigned_multiplier8_xor_enc64_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   operand1_i,
  input  logic [OP_W-1:0]   operand2_i,
  input  logic [KEY_W-1:0]  keyinput,
  output logic [RES_W-1:0]  result_o
);

  // A site inverts its net exactly when its key bit disagrees with the correct
  // key; folding K_CORRECT in lets synthesis pick XOR or XNOR per bit.
  logic [KEY_W-1:0] key_diff;
  assign key_diff = keyinput ^ K_CORRECT;

  logic [NUM_BLK-1:0][PP_W-1:0] pp;
  logic [NUM_BLK-1:0][PP_W-1:0] pp_locked;

  for (genvar p = 0; p < SLICES; p++) begin : g_a
    for (genvar q = 0; q < SLICES; q++) begin : g_b
      localparam int J = SLICES * p + q;

      udm2x2 u_blk (
        .a_i (operand1_i[SLICE_W*p +: SLICE_W]),
        .b_i (operand2_i[SLICE_W*q +: SLICE_W]),
        .y_o (pp[J])
      );

      assign pp_locked[J] = pp[J] ^ key_diff[PP_SITE_BASE + PP_W*J +: PP_W];
    end
  end

  logic [RES_W-1:0] sum;
  logic [RES_W-1:0] result_d;
  logic [RES_W-1:0] result_q;

  // NOTE: every variable written here gets a value before any conditional or
  // loop touches it, so no path leaves it holding state and no latch is inferred.
  always_comb begin
    sum = '0;
    for (int p = 0; p < SLICES; p++) begin
      for (int q = 0; q < SLICES; q++) begin
        sum = sum + (RES_W'(pp_locked[SLICES*p + q]) << (SLICE_W * (p + q)));
      end
    end
    result_d = sum ^ key_diff[SUM_SITE_BASE +: RES_W];
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // its _d value from before the edge, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result_q <= '0;
    else        result_q <= result_d;
  end

  assign result_o = result_q;

endmodule : underdesigned_multiplier8_xor_enc64

// File: tb/tb_underdesigned_multiplier8_xor_enc64.sv
// Directed and exhaustive checks of the locked approximate multiplier against
// hand-computed values and a small reference model.
module tb_underdesigned_multiplier8_xor_enc64;

  localparam logic [63:0] K_GOLD = 64'hA125EF80FFDBD9B5;

  logic        clk;
  logic        rst_n;
  logic [7:0]  operand1_i;
  logic [7:0]  operand2_i;
  logic [63:0] keyinput;
  logic [15:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;

  underdesigned_multiplier8_xor_enc64 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .operand1_i (operand1_i),
    .operand2_i (operand2_i),
    .keyinput   (keyinput),
    .result_o   (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: approximate 2x2 partial products, key errors injected on the
  // partial-product bits and on the final sum bits.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [63:0] key);
    logic [63:0] diff;
    logic [31:0] acc;
    int          pp;
    int          j;
    diff = key ^ K_GOLD;
    acc  = 0;
    for (int p = 0; p < 4; p++) begin
      for (int q = 0; q < 4; q++) begin
        j  = 4 * p + q;
        pp = int'(a[2*p +: 2]) * int'(b[2*q +: 2]);
        if (pp == 9) pp = 7;
        pp = pp ^ int'(diff[3*j +: 3]);
        acc = acc + (32'(pp) << (2 * (p + q)));
      end
    end
    return acc[15:0] ^ diff[63:48];
  endfunction

  task automatic apply(input logic [7:0] a, input logic [7:0] b);
    operand1_i = a;
    operand2_i = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] flip(input logic [63:0] k, input int bit_idx);
    logic [63:0] r;
    r = k;
    r[bit_idx] = ~r[bit_idx];
    return r;
  endfunction

  logic [63:0] k_multi [4];
  logic [7:0]  a_multi [4];
  logic [7:0]  b_multi [4];

  initial begin
    rst_n      = 1'b0;
    keyinput   = K_GOLD;
    operand1_i = 8'h03;
    operand2_i = 8'h03;

    // Reset state, with a clock edge passing while reset is held.
    #12;
    check("reset", result_o, 16'h0000);
    rst_n = 1'b1;

    apply(8'h03, 8'h03); check("3x3", result_o, 16'h0007);
    apply(8'h02, 8'h03); check("2x3", result_o, 16'h0006);

    apply(8'hFF, 8'hFF); check("FFxFF", result_o, 16'hC58F);
    apply(8'h10, 8'h10); check("10x10", result_o, 16'h0100);
    apply(8'h00, 8'hA5); check("00xA5", result_o, 16'h0000);
    apply(8'hFF, 8'h01); check("FFx01", result_o, 16'h00FF);
    apply(8'hA5, 8'h5A); check("A5x5A", result_o, model(8'hA5, 8'h5A, K_GOLD));

    // Single-bit wrong keys.
    keyinput = 64'hA125EF80FFDBD9A5;
    apply(8'h00, 8'h00); check("key_b4", result_o, 16'h0008);
    keyinput = 64'hA325EF80FFDBD9B5;
    apply(8'h00, 8'h00); check("key_b57_0", result_o, 16'h0200);
    apply(8'h03, 8'h03); check("key_b57_3x3", result_o, 16'h0207);
    keyinput = flip(K_GOLD, 48);
    apply(8'h00, 8'h00); check("key_b48", result_o, 16'h0001);

    // Multi-bit wrong keys: Hamming distance 2, 3, 4 and 6.
    k_multi[0] = flip(flip(K_GOLD, 0), 50);
    k_multi[1] = flip(flip(flip(K_GOLD, 2), 20), 63);
    k_multi[2] = flip(flip(flip(flip(K_GOLD, 5), 17), 33), 48);
    k_multi[3] = flip(flip(flip(flip(flip(flip(K_GOLD, 1), 9), 22), 40), 47), 55);
    a_multi = '{8'hA7, 8'h3C, 8'hFF, 8'h5B};
    b_multi = '{8'h5C, 8'hC3, 8'hFF, 8'h00};
    for (int i = 0; i < 4; i++) begin
      keyinput = k_multi[i];
      apply(a_multi[i], b_multi[i]);
      check($sformatf("key_multi%0d", i), result_o, model(a_multi[i], b_multi[i], k_multi[i]));
    end

    // Asynchronous reset mid-stream, asserted and released away from clock edges.
    keyinput = K_GOLD;
    apply(8'hA5, 8'h5A);
    #2 rst_n = 1'b0;
    #1 check("async_rst", result_o, 16'h0000);
    @(posedge clk); #1;
    check("rst_hold", result_o, 16'h0000);
    #2 rst_n = 1'b1;
    #1 check("rst_rel_pre_edge", result_o, 16'h0000);
    @(posedge clk); #1;
    check("rst_rel_first", result_o, model(8'hA5, 8'h5A, K_GOLD));

    // Exhaustive sweep with the correct key.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        apply(8'(a), 8'(b));
        check($sformatf("exh_%02hx_%02hx", a[7:0], b[7:0]), result_o,
              model(8'(a), 8'(b), K_GOLD));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_underdesigned_multiplier8_xor_enc64
